vga_scan_sequencer: RTL and testbench
=====================================

VGA_SCAN_SEQUENCER -- requirements
Module: vga_scan_sequencer

Interface
REQ-001 SHALL have parameter SCREEN_TO_WORLD_RATIO_COL, default 6: screen pixels per world column.
REQ-002 SHALL have parameter SCREEN_TO_WORLD_RATIO_ROW, default 6: screen lines per world row.
REQ-003 SHALL have parameter WORLD_COLS, default 128: world map columns.
REQ-004 SHALL have parameter WORLD_ROWS, default 128: world map rows.
REQ-005 SHALL have parameter MARGIN, default 128: left blank pixels before the map window.
REQ-006 SHALL have port clk, input, 1: pixel clock; one pixel per rising edge; sole clock.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port video_on, input, 1: DTG active-video flag for the current pixel.
REQ-009 SHALL have port pixel_row, input, 12: DTG row of the current pixel.
REQ-010 SHALL have port pixel_column, input, 12: DTG column of the current pixel.
REQ-011 SHALL have port world_row, output, 7: registered world row.
REQ-012 SHALL have port world_column, output, 7: registered world column.
REQ-013 SHALL have port vid_addr, output, 14: {world_row, world_column}.
REQ-014 SHALL have port map_valid, output, 1: the pixel lies inside the map window.
REQ-015 SHALL have port frame_start, output, 1: one-cycle pulse for pixel (0,0).
REQ-016 SHALL have port sync_err, output, 1: sticky self-check mismatch flag.

Function
REQ-017 SHALL derive all outputs from incremental counters (sub-column 0..RATIO_COL-1, world column, sub-row 0..RATIO_ROW-1, world row), with no division or search loops.
REQ-018 SHALL register all outputs: the pixel presented at cycle t appears on the outputs at cycle t+1.
REQ-019 SHALL implement states WAIT_FRAME, LEFT, MAP and LINE_DONE.
REQ-020 WAIT_FRAME SHALL move to LEFT, zero the row counters and pulse frame_start on video_on=1, pixel_row=0, pixel_column=0.
REQ-021 LEFT SHALL move to MAP on video_on=1 with pixel_column==MARGIN, loading sub-column=0 and world column=0.
REQ-022 MAP SHALL advance sub-column once per cycle and, when sub-column wraps from RATIO_COL-1 to 0, increment world column.
REQ-023 MAP SHALL move to LINE_DONE on the cycle it processes world column WORLD_COLS-1 with sub-column RATIO_COL-1.
REQ-024 LINE_DONE SHALL, on the first cycle with video_on=0, advance the row counters; after the last row is completed (world row WORLD_ROWS-1, sub-row RATIO_ROW-1) it SHALL move to WAIT_FRAME, otherwise to LEFT.
REQ-025 SHALL abort to WAIT_FRAME without advancing the row counters if video_on falls while in MAP.
REQ-026 SHALL drive map_valid=1 only for pixels processed in MAP; world_row, world_column and vid_addr SHALL be 0 whenever map_valid=0.
REQ-027 SHALL treat pixels with pixel_column >= MARGIN+WORLD_COLS*RATIO_COL as outside the window; with the defaults, columns 896..1023 give map_valid=0.
REQ-028 SHALL let frame_start take priority over any other transition when pixel (0,0) arrives in any state, resynchronising the counters.

Reset
REQ-029 On reset=1 at a clock edge, the state SHALL become WAIT_FRAME, all counters 0, and world_row, world_column, vid_addr, map_valid, frame_start and sync_err 0.
REQ-030 A reset mid-frame SHALL hold map_valid=0 until the next pixel (0,0) is processed.

Configuration
REQ-031 Macro VGA_SCAN_SELFCHECK_EN defined: each cycle in MAP, SHALL compute the expected column ((pixel_column-MARGIN)/RATIO_COL) and expected row (pixel_row/RATIO_ROW) and compare them with the counters; any mismatch SHALL set sync_err until reset.
REQ-032 Macro VGA_SCAN_SELFCHECK_EN undefined: no checker logic SHALL exist and sync_err SHALL be tied to 0.

Verification
REQ-033 Full 1024x768 frame, defaults -> frame_start pulses once, one cycle after (0,0); (row 0, col 128) -> next cycle vid_addr=0x0000, map_valid=1.
REQ-034 (row 0, col 133) -> world_column=0; (row 0, col 134) -> world_column=1; (row 0, col 895) -> world_column=127; (row 0, col 896) -> map_valid=0, vid_addr=0.
REQ-035 (row 6, col 128) -> world_row=1, vid_addr=0x0080; (row 767, col 895) -> vid_addr=0x3FFF; (row 5, col 140) -> vid_addr=0x0002.
REQ-036 Reset asserted at (row 300, col 500) for one cycle -> next cycle all outputs 0; map_valid stays 0 through the rest of that frame and resumes at (row 0, col 128) of the next frame.
REQ-037 video_on dropped at (row 10, col 400) -> map_valid=0 the next cycle; the state is WAIT_FRAME until the next pixel (0,0).
REQ-038 With VGA_SCAN_SELFCHECK_EN defined, skip one DTG column mid-line -> sync_err=1 and it stays 1 until reset; with the macro undefined, the same stimulus -> sync_err=0.

Source files
------------

// File: rtl/vga_scan_sequencer.sv
// vga_scan_sequencer: maps the DTG pixel stream onto world-map coordinates.
// A scaled map window of WORLD_COLS x WORLD_ROWS cells starts MARGIN pixels
// from the left edge. Coordinates come from incremental counters, so the
// module needs no divider on the main path. All outputs are registered and
// show the pixel that was presented one cycle earlier.
// Optional build macro: VGA_SCAN_SELFCHECK_EN. When it is defined, a checker
// compares the counters against a division of the DTG position and sets the
// sticky flag sync_err on any mismatch. When it is undefined, sync_err is 0.
//
// state      | meaning
// WAIT_FRAME | idle until pixel (0,0) arrives
// LEFT       | left margin of a line; waiting for column MARGIN
// MAP        | inside the map window; column counters advance every pixel
// LINE_DONE  | map row finished; waits for blanking to advance the row
module vga_scan_sequencer #(
    parameter int SCREEN_TO_WORLD_RATIO_COL = 6,
    parameter int SCREEN_TO_WORLD_RATIO_ROW = 6,
    parameter int WORLD_COLS                = 128,
    parameter int WORLD_ROWS                = 128,
    parameter int MARGIN                    = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [11:0] pixel_row,
    input  logic [11:0] pixel_column,
    output logic [6:0]  world_row,
    output logic [6:0]  world_column,
    output logic [13:0] vid_addr,
    output logic        map_valid,
    output logic        frame_start,
    output logic        sync_err
);

    localparam int SCW = (SCREEN_TO_WORLD_RATIO_COL > 1) ? $clog2(SCREEN_TO_WORLD_RATIO_COL) : 1;
    localparam int SRW = (SCREEN_TO_WORLD_RATIO_ROW > 1) ? $clog2(SCREEN_TO_WORLD_RATIO_ROW) : 1;

    localparam logic [SCW-1:0] SUB_COL_LAST = SCW'(SCREEN_TO_WORLD_RATIO_COL - 1);
    localparam logic [SRW-1:0] SUB_ROW_LAST = SRW'(SCREEN_TO_WORLD_RATIO_ROW - 1);
    localparam logic [SCW-1:0] SUB_COL_ONE  = SCW'(1);
    localparam logic [SRW-1:0] SUB_ROW_ONE  = SRW'(1);
    localparam logic [6:0]     COL_LAST     = 7'(WORLD_COLS - 1);
    localparam logic [6:0]     ROW_LAST     = 7'(WORLD_ROWS - 1);
    localparam logic [11:0]    MARGIN_COL   = 12'(MARGIN);

    typedef enum logic [1:0] {
        S_WAIT_FRAME = 2'd0,
        S_LEFT       = 2'd1,
        S_MAP        = 2'd2,
        S_LINE_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d, st_eff;
    logic [SCW-1:0] sub_col_q, sub_col_d, cur_sub;
    logic [6:0]     col_q, col_d, cur_col;
    logic [SRW-1:0] sub_row_q, sub_row_d, sub_row_eff;
    logic [6:0]     row_q, row_d, row_eff;

    logic           frame_hit;
    logic           map_pix;
    logic           col_last;

    logic [6:0]     world_row_q, world_row_d;
    logic [6:0]     world_col_q, world_col_d;
    logic           map_valid_q, map_valid_d;
    logic           frame_start_q, frame_start_d;

    assign frame_hit = video_on && (pixel_row == 12'd0) && (pixel_column == 12'd0);

    // State and scan counters
    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q   <= S_WAIT_FRAME;
            sub_col_q <= '0;
            col_q     <= '0;
            sub_row_q <= '0;
            row_q     <= '0;
        end else begin
            state_q   <= state_d;
            sub_col_q <= sub_col_d;
            col_q     <= col_d;
            sub_row_q <= sub_row_d;
            row_q     <= row_d;
        end
    end

    // Next state and counter update; pixel (0,0) overrides the current state
    // so a lost or aborted frame always resynchronises here.
    always_comb begin : next_state
        st_eff      = frame_hit ? S_LEFT : state_q;
        sub_row_eff = frame_hit ? '0 : sub_row_q;
        row_eff     = frame_hit ? '0 : row_q;
        // The pixel at column MARGIN is the first map pixel, handled with
        // freshly loaded column counters while the state is still LEFT.
        cur_sub     = (st_eff == S_MAP) ? sub_col_q : '0;
        cur_col     = (st_eff == S_MAP) ? col_q : '0;
        map_pix     = video_on && ((st_eff == S_MAP) ||
                                   ((st_eff == S_LEFT) && (pixel_column == MARGIN_COL)));
        col_last    = (cur_col == COL_LAST) && (cur_sub == SUB_COL_LAST);

        state_d     = st_eff;
        sub_col_d   = sub_col_q;
        col_d       = col_q;
        sub_row_d   = sub_row_eff;
        row_d       = row_eff;

        case (st_eff)
            S_LEFT, S_MAP: begin
                if (map_pix) begin
                    state_d = col_last ? S_LINE_DONE : S_MAP;
                    if (cur_sub == SUB_COL_LAST) begin
                        sub_col_d = '0;
                        col_d     = cur_col + 7'd1;
                    end else begin
                        sub_col_d = cur_sub + SUB_COL_ONE;
                        col_d     = cur_col;
                    end
                end else if (st_eff == S_MAP) begin
                    // video dropped inside the window: row position is lost
                    state_d = S_WAIT_FRAME;
                end
            end
            S_LINE_DONE: begin
                if (!video_on) begin
                    if (sub_row_eff == SUB_ROW_LAST) begin
                        sub_row_d = '0;
                        if (row_eff == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_WAIT_FRAME;
                        end else begin
                            row_d   = row_eff + 7'd1;
                            state_d = S_LEFT;
                        end
                    end else begin
                        sub_row_d = sub_row_eff + SUB_ROW_ONE;
                        state_d   = S_LEFT;
                    end
                end
            end
            default: begin
                state_d = st_eff;
            end
        endcase
    end

    // Output values for the pixel being processed this cycle
    always_comb begin : out_logic
        map_valid_d   = map_pix;
        world_row_d   = map_pix ? row_eff : '0;
        world_col_d   = map_pix ? cur_col : '0;
        frame_start_d = frame_hit;
    end

    // Output registers
    always_ff @(posedge clk) begin : out_reg
        if (reset) begin
            world_row_q   <= '0;
            world_col_q   <= '0;
            map_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            world_row_q   <= world_row_d;
            world_col_q   <= world_col_d;
            map_valid_q   <= map_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign world_row    = world_row_q;
    assign world_column = world_col_q;
    assign vid_addr     = {world_row_q, world_col_q};
    assign map_valid    = map_valid_q;
    assign frame_start  = frame_start_q;

`ifdef VGA_SCAN_SELFCHECK_EN
    logic [11:0] exp_col;
    logic [11:0] exp_row;
    logic        mismatch;
    logic        sync_err_q;

    // Reference position by constant division, compared on every map pixel
    always_comb begin : self_check
        exp_col  = (pixel_column - MARGIN_COL) / 12'(SCREEN_TO_WORLD_RATIO_COL);
        exp_row  = pixel_row / 12'(SCREEN_TO_WORLD_RATIO_ROW);
        mismatch = map_pix && ((exp_col != {5'd0, cur_col}) || (exp_row != {5'd0, row_eff}));
    end

    // Sticky mismatch flag, cleared only by reset
    always_ff @(posedge clk) begin : sync_err_reg
        if (reset) begin
            sync_err_q <= 1'b0;
        end else if (mismatch) begin
            sync_err_q <= 1'b1;
        end
    end

    assign sync_err = sync_err_q;
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_sequencer.sv
// Directed bench for vga_scan_sequencer: checkpoint table applied over a
// scanned frame, plus hand sequences for video drop, mid-frame reset,
// a full small-ratio frame and the column-skip self-check.
module tb_vga_scan_sequencer;

`ifdef VGA_SCAN_SELFCHECK_EN
    localparam logic SELFCHK = 1'b1;
`else
    localparam logic SELFCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;

    logic [6:0]  a_world_row, a_world_column;
    logic [13:0] a_vid_addr;
    logic        a_map_valid, a_frame_start, a_sync_err;

    logic [6:0]  b_world_row, b_world_column;
    logic [13:0] b_vid_addr;
    logic        b_map_valid, b_frame_start, b_sync_err;

    always #5 clk = ~clk;

    vga_scan_sequencer dut_a (
        .clk          (clk),
        .reset        (reset),
        .video_on     (video_on),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .world_row    (a_world_row),
        .world_column (a_world_column),
        .vid_addr     (a_vid_addr),
        .map_valid    (a_map_valid),
        .frame_start  (a_frame_start),
        .sync_err     (a_sync_err)
    );

    // 1:1 scaling so a whole 128x128 map frame fits in a short run
    vga_scan_sequencer #(
        .SCREEN_TO_WORLD_RATIO_COL (1),
        .SCREEN_TO_WORLD_RATIO_ROW (1)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .video_on     (video_on),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .world_row    (b_world_row),
        .world_column (b_world_column),
        .vid_addr     (b_vid_addr),
        .map_valid    (b_map_valid),
        .frame_start  (b_frame_start),
        .sync_err     (b_sync_err)
    );

    typedef struct {
        int          row;
        int          col;
        logic        valid;
        logic [13:0] addr;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   fs_count = 0;
    int   valid_count = 0;
    bit   use_tbl  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int r, input int c, input logic v, input logic [13:0] a, input string n);
        vec_t e;
        e.row = r; e.col = c; e.valid = v; e.addr = a; e.name = n;
        vecs.push_back(e);
    endtask

    // Present one pixel; outputs are sampled 1 ns after the edge that takes it
    task automatic pix(input logic von, input int r, input int c);
        video_on     = von;
        pixel_row    = 12'(r);
        pixel_column = 12'(c);
        @(posedge clk);
        #1;
        if (a_frame_start) fs_count++;
        if (a_map_valid) valid_count++;
        if (use_tbl && von) begin
            for (int i = 0; i < vecs.size(); i++) begin
                if (vecs[i].row == r && vecs[i].col == c) begin
                    check({vecs[i].name, "_valid"}, 32'(a_map_valid), 32'(vecs[i].valid));
                    check({vecs[i].name, "_addr"}, 32'(a_vid_addr), 32'(vecs[i].addr));
                    check({vecs[i].name, "_wrow"}, 32'(a_world_row), 32'(vecs[i].addr[13:7]));
                    check({vecs[i].name, "_wcol"}, 32'(a_world_column), 32'(vecs[i].addr[6:0]));
                end
            end
        end
    endtask

    task automatic line(input int r, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) pix(1'b1, r, c);
        pix(1'b0, r, 1100);
    endtask

    task automatic check_a_zero(input string name);
        check({name, "_valid"}, 32'(a_map_valid), 32'd0);
        check({name, "_addr"}, 32'(a_vid_addr), 32'd0);
        check({name, "_wrow"}, 32'(a_world_row), 32'd0);
        check({name, "_wcol"}, 32'(a_world_column), 32'd0);
        check({name, "_fs"}, 32'(a_frame_start), 32'd0);
        check({name, "_serr"}, 32'(a_sync_err), 32'd0);
    endtask

    initial begin
        add_vec(0,  127,  1'b0, 14'h0000, "r0c127");
        add_vec(0,  128,  1'b1, 14'h0000, "r0c128");
        add_vec(0,  133,  1'b1, 14'h0000, "r0c133");
        add_vec(0,  134,  1'b1, 14'h0001, "r0c134");
        add_vec(0,  895,  1'b1, 14'h007F, "r0c895");
        add_vec(0,  896,  1'b0, 14'h0000, "r0c896");
        add_vec(0,  1023, 1'b0, 14'h0000, "r0c1023");
        add_vec(5,  140,  1'b1, 14'h0002, "r5c140");
        add_vec(5,  895,  1'b1, 14'h007F, "r5c895");
        add_vec(6,  128,  1'b1, 14'h0080, "r6c128");
        add_vec(7,  500,  1'b1, 14'h00BE, "r7c500");
        add_vec(11, 895,  1'b1, 14'h00FF, "r11c895");
        add_vec(11, 896,  1'b0, 14'h0000, "r11c896");

        reset = 1'b1; video_on = 1'b0; pixel_row = '0; pixel_column = '0;
        repeat (2) @(posedge clk);
        #1;
        check_a_zero("reset");
        reset = 1'b0;

        // Frame 1: checkpoint table over the first 12 lines
        fs_count = 0;
        pix(1'b1, 0, 0);
        check("fs_after_origin", 32'(a_frame_start), 32'd1);
        check("origin_valid", 32'(a_map_valid), 32'd0);
        use_tbl = 1;
        pix(1'b1, 0, 1);
        check("fs_one_cycle", 32'(a_frame_start), 32'd0);
        line(0, 2, 1023);
        for (int r = 1; r < 12; r++) line(r, 120, 1023);
        use_tbl = 0;
        check("fs_count_frame1", 32'(fs_count), 32'd1);
        check("serr_honest_frame", 32'(a_sync_err), 32'd0);

        // Frame 2: video drops inside the window at (10,400)
        pix(1'b1, 0, 0);
        check("fs_frame2", 32'(a_frame_start), 32'd1);
        line(0, 120, 1023);
        for (int r = 1; r < 10; r++) line(r, 120, 1023);
        for (int c = 120; c < 400; c++) pix(1'b1, 10, c);
        check("r10c399_valid", 32'(a_map_valid), 32'd1);
        check("r10c399_addr", 32'(a_vid_addr), 32'h00AD);
        pix(1'b0, 10, 400);
        check("drop_valid", 32'(a_map_valid), 32'd0);
        check("drop_addr", 32'(a_vid_addr), 32'd0);
        valid_count = 0;
        for (int c = 401; c < 1024; c++) pix(1'b1, 10, c);
        pix(1'b0, 10, 1100);
        line(11, 0, 1023);
        check("drop_stays_idle", 32'(valid_count), 32'd0);
        pix(1'b1, 0, 0);
        check("fs_after_drop", 32'(a_frame_start), 32'd1);
        pix(1'b1, 0, 128);
        check("resume_valid", 32'(a_map_valid), 32'd1);
        check("resume_addr", 32'(a_vid_addr), 32'd0);

        // Mid-frame reset at (300,500)
        for (int c = 129; c < 500; c++) pix(1'b1, 300, c);
        check("pre_reset_valid", 32'(a_map_valid), 32'd1);
        reset = 1'b1;
        pix(1'b1, 300, 500);
        reset = 1'b0;
        check_a_zero("mid_reset");
        valid_count = 0;
        for (int c = 501; c < 1024; c++) pix(1'b1, 300, c);
        pix(1'b0, 300, 1100);
        line(301, 0, 1023);
        line(767, 0, 1023);
        pix(1'b0, 780, 0);
        check("reset_hold_invalid", 32'(valid_count), 32'd0);
        pix(1'b1, 0, 0);
        check("fs_after_reset", 32'(a_frame_start), 32'd1);
        pix(1'b1, 0, 128);
        check("post_reset_valid", 32'(a_map_valid), 32'd1);
        check("post_reset_addr", 32'(a_vid_addr), 32'd0);
        pix(1'b0, 0, 1100);

        // Full 1:1 frame on instance B, ending at the last map cell
        pix(1'b1, 0, 0);
        check("b_fs", 32'(b_frame_start), 32'd1);
        for (int r = 0; r < 128; r++) begin
            for (int c = 128; c < 256; c++) begin
                pix(1'b1, r, c);
                if (r == 0 && c == 128) check("b_r0c128", 32'(b_vid_addr), 32'h0000);
                if (r == 0 && c == 255) check("b_r0c255", 32'(b_vid_addr), 32'h007F);
                if (r == 1 && c == 128) check("b_r1c128", 32'(b_vid_addr), 32'h0080);
                if (r == 127 && c == 255) begin
                    check("b_last_valid", 32'(b_map_valid), 32'd1);
                    check("b_last_addr", 32'(b_vid_addr), 32'h3FFF);
                end
            end
            pix(1'b0, r, 1100);
        end
        pix(1'b1, 128, 128);
        check("b_after_last_row", 32'(b_map_valid), 32'd0);
        check("b_serr_honest", 32'(b_sync_err), 32'd0);
        pix(1'b0, 128, 1100);

        // Column 301 skipped mid-line on instance A
        pix(1'b1, 0, 0);
        for (int c = 128; c <= 300; c++) pix(1'b1, 0, c);
        check("serr_before_skip", 32'(a_sync_err), 32'd0);
        for (int c = 302; c <= 400; c++) pix(1'b1, 0, c);
        check("serr_after_skip", 32'(a_sync_err), 32'(SELFCHK));
        pix(1'b0, 0, 1100);
        pix(1'b1, 0, 0);
        check("serr_sticky", 32'(a_sync_err), 32'(SELFCHK));
        reset = 1'b1;
        pix(1'b0, 0, 1100);
        reset = 1'b0;
        check("serr_cleared", 32'(a_sync_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
